half_duplex_link: RTL and testbench

//  Half-duplex serial node on one shared, pulled-up tristate wire. It is the

---
 rtl/half_duplex_link_if.sv | 26 ++
 rtl/half_duplex_link.sv | 155 +++++++++++++++
 tb/tb_half_duplex_link.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/half_duplex_link_if.sv
// Client-side signal bundle for half_duplex_link.
// The master side is the byte-stream client; the slave side is the link node.
// dbg_state mirrors the node's FSM state for observation only.
interface half_duplex_link_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_err;
  logic              drive_en;
  logic              busy;
  logic [2:0]        dbg_state;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, rx_err, drive_en, busy, dbg_state
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, rx_err, drive_en, busy, dbg_state
  );
endinterface

// File: rtl/half_duplex_link.sv
// Half-duplex single-wire serial node.
// Frame: start bit 0, DATA_W data bits LSB first, stop bit 1, one bit per clk.
// The node drives the shared line only while sending its own frame and leaves
// it released (Z, pulled up) otherwise. After its own stop bit it stays off
// the line for TURN_CYCLES cycles so the far end can take over cleanly.
//
// Handshake (TX): a frame is accepted at a rising edge where tx_valid and
// tx_ready are both 1; tx_data is captured at that edge and may change after.
// tx_ready is combinational and only high in IDLE, outside reset, while the
// line is not being pulled low by the far end (an incoming start bit wins).
module half_duplex_link #(
  parameter int DATA_W      = 8,
  parameter int TURN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire              bus,
  half_duplex_link_if.slave link
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TX_START = 3'd1,
    ST_TX_DATA  = 3'd2,
    ST_TX_STOP  = 3'd3,
    ST_TURN     = 3'd4,
    ST_RX_DATA  = 3'd5,
    ST_RX_STOP  = 3'd6
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_rx_data;
  logic [CW-1:0]     r_bit_cnt;
  logic [TW-1:0]     r_turn_cnt;
  logic              r_drive_en;
  logic              r_bus_out;
  logic              r_rx_valid;
  logic              r_rx_err;
  logic              r_busy;

  // Only a clean 0 counts as low; X or Z on the line reads as released (1).
  logic w_bus_low;
  logic w_bus_bit;
  logic w_accept;

  assign w_bus_low = (bus === 1'b0);
  assign w_bus_bit = !w_bus_low;
  assign w_accept  = link.tx_valid && link.tx_ready;

  assign bus            = r_drive_en ? r_bus_out : 1'bz;
  assign link.tx_ready  = (r_state == ST_IDLE) && !w_bus_low && !rst;
  assign link.rx_data   = r_rx_data;
  assign link.rx_valid  = r_rx_valid;
  assign link.rx_err    = r_rx_err;
  assign link.drive_en  = r_drive_en;
  assign link.busy      = r_busy;
  assign link.dbg_state = r_state;

  // Link FSM: TX serialisation, turnaround, RX deserialisation, result pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_rx_data  <= '0;
      r_bit_cnt  <= '0;
      r_turn_cnt <= '0;
      r_drive_en <= 1'b0;
      r_bus_out  <= 1'b1;
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_bit_cnt <= '0;
          if (w_bus_low) begin
            // Far end started a frame; receive takes priority over TX.
            r_state <= ST_RX_DATA;
            r_busy  <= 1'b1;
          end else if (w_accept) begin
            r_shift    <= link.tx_data;
            r_state    <= ST_TX_START;
            r_drive_en <= 1'b1;
            r_bus_out  <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        ST_TX_START: begin
          r_bus_out <= r_shift[0];
          r_shift   <= r_shift >> 1;
          r_bit_cnt <= '0;
          r_state   <= ST_TX_DATA;
        end
        ST_TX_DATA: begin
          if (r_bit_cnt == CW'(DATA_W - 1)) begin
            r_bus_out <= 1'b1;
            r_state   <= ST_TX_STOP;
          end else begin
            r_bus_out <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        ST_TX_STOP: begin
          r_drive_en <= 1'b0;
          r_bus_out  <= 1'b1;
          r_turn_cnt <= '0;
          r_state    <= ST_TURN;
        end
        ST_TURN: begin
          // Line is released but neither TX nor RX may start yet.
          if (r_turn_cnt == TW'(TURN_CYCLES - 1)) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_bit_cnt <= '0;
          end else begin
            r_turn_cnt <= r_turn_cnt + TW'(1);
          end
        end
        ST_RX_DATA: begin
          r_shift <= {w_bus_bit, r_shift[DATA_W-1:1]};
          if (r_bit_cnt == CW'(DATA_W - 1)) begin
            r_state <= ST_RX_STOP;
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        ST_RX_STOP: begin
          if (w_bus_bit) begin
            r_rx_data  <= r_shift;
            r_rx_valid <= 1'b1;
          end else begin
            r_rx_err <= 1'b1;
          end
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_bit_cnt <= '0;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
          r_drive_en <= 1'b0;
          r_bit_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_half_duplex_link.sv
// Bench for half_duplex_link: the far-end node and the line pull-up are
// modelled here, next to a transaction-level model of the expected link.
module tb_half_duplex_link;

  localparam int DATA_W      = 8;
  localparam int TURN_CYCLES = 2;

  // ---------------- clock / reset / line ----------------
  logic clk = 1'b0;
  logic rst;
  logic tb_drv;
  logic tb_val;
  wire  bus;

  pullup (bus);
  assign bus = tb_drv ? tb_val : 1'bz;

  always #5 clk = ~clk;

  half_duplex_link_if #(.DATA_W(DATA_W)) link ();

  half_duplex_link #(
    .DATA_W     (DATA_W),
    .TURN_CYCLES(TURN_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .link(link)
  );

  // ---------------- counters ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int n_valid_seen = 0;
  int n_err_seen   = 0;
  int n_de_seen    = 0;
  bit chk_en = 1'b0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk8(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // exp_q holds the values the node must put on the line, one per cycle,
  // front = current cycle. m_turn counts remaining silent cycles after our
  // stop bit; m_rx_left counts remaining bits of an incoming frame.
  logic              exp_q[$];
  int                m_turn    = 0;
  int                m_rx_left = 0;
  logic [DATA_W-1:0] m_rx_bits = '0;
  logic [DATA_W-1:0] m_rx_data = '0;
  logic              m_rx_valid = 1'b0;
  logic              m_rx_err   = 1'b0;
  logic              m_acc      = 1'b0;

  function automatic logic exp_line();
    if (tb_drv) return tb_val;
    if (exp_q.size() != 0) return exp_q[0];
    return 1'b1;
  endfunction

  function automatic logic m_idle();
    return (exp_q.size() == 0) && (m_turn == 0) && (m_rx_left == 0);
  endfunction

  always @(posedge clk) begin
    logic line;
    line  = exp_line();
    m_acc = 1'b0;
    if (rst) begin
      exp_q.delete();
      m_turn     = 0;
      m_rx_left  = 0;
      m_rx_valid = 1'b0;
      m_rx_err   = 1'b0;
      m_rx_data  = '0;
    end else begin
      m_rx_valid = 1'b0;
      m_rx_err   = 1'b0;
      if (exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) m_turn = TURN_CYCLES;
      end else if (m_turn != 0) begin
        m_turn--;
      end else if (m_rx_left != 0) begin
        if (m_rx_left > 1) m_rx_bits[DATA_W + 1 - m_rx_left] = line;
        else if (line) begin
          m_rx_data  = m_rx_bits;
          m_rx_valid = 1'b1;
        end else begin
          m_rx_err = 1'b1;
        end
        m_rx_left--;
      end else if (line == 1'b0) begin
        m_rx_left = DATA_W + 1;
      end else if (link.tx_valid) begin
        exp_q.push_back(1'b0);
        for (int i = 0; i < DATA_W; i++) exp_q.push_back(link.tx_data[i]);
        exp_q.push_back(1'b1);
        m_acc = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      logic el;
      el = exp_line();
      chk1("bus", bus, el);
      chk1("drive_en", link.drive_en, exp_q.size() != 0);
      chk1("tx_ready", link.tx_ready, !rst && m_idle() && el);
      chk1("busy", link.busy, !m_idle());
      chk1("rx_valid", link.rx_valid, m_rx_valid);
      chk1("rx_err", link.rx_err, m_rx_err);
      chk8("rx_data", link.rx_data, m_rx_data);
      if (link.rx_valid === 1'b1) n_valid_seen++;
      if (link.rx_err === 1'b1)   n_err_seen++;
      if (link.drive_en === 1'b1) n_de_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Far-end frame; called and returns just after a rising edge.
  task automatic far_frame(input logic [DATA_W-1:0] d, input logic stop_b);
    tb_drv = 1'b1;
    tb_val = 1'b0;
    step();
    for (int i = 0; i < DATA_W; i++) begin
      tb_val = d[i];
      step();
    end
    tb_val = stop_b;
    step();
    tb_drv = 1'b0;
    tb_val = 1'b1;
  endtask

  task automatic wait_accept();
    int k;
    k = 0;
    while (k < 40) begin
      step();
      k++;
      if (m_acc) break;
    end
    if (!m_acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got none expected accept within 40 cycles at %0t", $time);
    end
    link.tx_valid = 1'b0;
    link.tx_data  = DATA_W'($urandom);
  endtask

  task automatic send_tx(input logic [DATA_W-1:0] d);
    link.tx_data  = d;
    link.tx_valid = 1'b1;
    wait_accept();
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!m_idle() && k < 64) begin
      step();
      k++;
    end
    if (!m_idle()) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout: got busy expected idle within 64 cycles at %0t", $time);
    end
  endtask

  // Line values just after accept: exp_bits[0] is the start bit, [9] the stop bit.
  task automatic check_frame(input logic [9:0] exp_bits, input string nm);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk1($sformatf("%s_line%0d", nm, k), bus, (k < 10) ? exp_bits[k] : 1'b1);
      chk1($sformatf("%s_de%0d", nm, k), link.drive_en, k < 10);
    end
    @(posedge clk);
    #1;
    chk1($sformatf("%s_ready_after_turn", nm), link.tx_ready, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int v0, e0, d0, r;
    rst           = 1'b1;
    tb_drv        = 1'b0;
    tb_val        = 1'b1;
    link.tx_valid = 1'b1;
    link.tx_data  = 8'hFF;

    // Reset held two cycles with tx_valid asserted.
    step();
    chk_en = 1'b1;
    step();
    chk1("rst_drive_en", link.drive_en, 1'b0);
    chk1("rst_bus", bus, 1'b1);
    chk1("rst_tx_ready", link.tx_ready, 1'b0);
    chk1("rst_rx_valid", link.rx_valid, 1'b0);
    chk8("rst_rx_data", link.rx_data, 8'h00);
    rst           = 1'b0;
    link.tx_valid = 1'b0;
    step();

    // TX of 8'hA5.
    send_tx(8'hA5);
    check_frame(10'b1101001010, "txA5");

    // Good RX of 8'h3C.
    step();
    v0 = n_valid_seen;
    e0 = n_err_seen;
    far_frame(8'h3C, 1'b1);
    step();
    step();
    chk8("rx3C_data", link.rx_data, 8'h3C);
    chk8("rx3C_valid_pulses", 8'(n_valid_seen - v0), 8'd1);
    chk8("rx3C_err_pulses", 8'(n_err_seen - e0), 8'd0);

    // Bad stop bit.
    v0 = n_valid_seen;
    e0 = n_err_seen;
    far_frame(8'h5A, 1'b0);
    step();
    step();
    chk8("badstop_err_pulses", 8'(n_err_seen - e0), 8'd1);
    chk8("badstop_valid_pulses", 8'(n_valid_seen - v0), 8'd0);
    chk8("badstop_data_held", link.rx_data, 8'h3C);

    // Start bit and tx_valid in the same IDLE cycle: RX first, TX after.
    d0 = n_de_seen;
    link.tx_data  = 8'h77;
    link.tx_valid = 1'b1;
    far_frame(8'h81, 1'b1);
    chk8("collide_de_cycles", 8'(n_de_seen - d0), 8'd0);
    wait_accept();
    chk8("collide_rx_data", link.rx_data, 8'h81);
    check_frame(10'b1011101110, "tx77");

    // Reset during TX bit 4, then a clean 8'hFF.
    step();
    send_tx(8'hC3);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    v0 = n_valid_seen;
    chk1("midrst_drive_en", link.drive_en, 1'b0);
    chk1("midrst_busy", link.busy, 1'b0);
    chk1("midrst_bus", bus, 1'b1);
    step();
    step();
    chk8("midrst_valid_pulses", 8'(n_valid_seen - v0), 8'd0);
    send_tx(8'hFF);
    check_frame(10'b1111111110, "txFF");

    // Randomised traffic.
    for (int it = 0; it < 60; it++) begin
      wait_idle();
      r = $urandom_range(0, 4);
      case (r)
        0: far_frame(DATA_W'($urandom), ($urandom_range(0, 3) != 0));
        1: send_tx(DATA_W'($urandom));
        2: begin
          link.tx_data  = DATA_W'($urandom);
          link.tx_valid = 1'b1;
          far_frame(DATA_W'($urandom), 1'b1);
          wait_accept();
        end
        3: repeat ($urandom_range(1, 4)) step();
        default: begin
          send_tx(DATA_W'($urandom));
          repeat ($urandom_range(0, 9)) step();
          rst = 1'b1;
          step();
          rst = 1'b0;
        end
      endcase
    end
    wait_idle();
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop if the run ever stalls.
  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish by 1000000 ns");
    $fatal(1, "watchdog");
  end

endmodule
